i2c_slave_regs: RTL

Parametrised I2C slave with a register-pointer protocol, the next generation of the team's byte-level I2C slave. It filters and synchronises SCL/SDA and decodes start, repeated start and stop. It matches a 7-bit device address, takes a register pointer byte, then issues burst writes or serves burst reads with pointer auto-increment. It sits between the board I2C pins (open-drain buffer outside this block) and an external register file on the `clk` domain.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_line_filter.sv | 54 +++++
 rtl/i2c_slave_regs.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the register-pointer I2C slave.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StDevAck,
        StPtr,
        StPtrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StIgnore
    } i2c_state_e;

    localparam logic [1:0] COND_NONE  = 2'b00;
    localparam logic [1:0] COND_START = 2'b01;
    localparam logic [1:0] COND_STOP  = 2'b10;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // SDA edges only mean start/stop while SCL is high.
    function automatic logic [1:0] bus_cond(input logic scl_lvl, input logic sda_rise,
                                            input logic sda_fall);
        if (scl_lvl && sda_fall) return COND_START;
        if (scl_lvl && sda_rise) return COND_STOP;
        return COND_NONE;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser, FILTER_LEN-sample level filter and registered edge pulses
// for one open-drain bus line.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic [3:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       prev_q, rise_q, fall_q;

    // cnt_q counts consecutive synchronised samples that disagree with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == 4'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            rise_q  <= level_q & ~prev_q;
            fall_q  <= ~level_q & prev_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave with device-address match, register pointer byte and auto-incrementing
// burst writes/reads towards an external register file.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter int unsigned  NUM_REGS   = 16,
    parameter int unsigned  FILTER_LEN = 3,
    localparam int unsigned PTR_W      = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [6:0]       my_dev_address,
    input  logic             scl,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             sda_oen,
    output logic             wr_ena,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             rd_strobe,
    output logic             busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic [1:0] cond;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk),
        .n_rst  (n_rst),
        .line_i (scl),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk),
        .n_rst  (n_rst),
        .line_i (sda_i),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign cond = bus_cond(scl_lvl, sda_rise, sda_fall);

    i2c_state_e       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       tx_q, tx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic             sda_o_q, sda_o_d;
    logic             sda_oen_q, sda_oen_d;
    logic             wr_ena_q, wr_ena_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             rd_strobe_q, rd_strobe_d;
    logic             busy_q, busy_d;

    assign ptr_inc = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        sda_o_d     = sda_o_q;
        sda_oen_d   = sda_oen_q;
        wr_ena_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_strobe_d = 1'b0;
        busy_d      = busy_q;

        // The read pointer advances the cycle after each byte is captured.
        if (rd_strobe_q) ptr_d = ptr_inc;

        if (cond == COND_START) begin
            state_d   = StDevAddr;
            bit_cnt_d = '0;
            sda_oen_d = 1'b0;
            sda_o_d   = 1'b1;
            busy_d    = 1'b1;
        end else if (cond == COND_STOP) begin
            state_d   = StIdle;
            sda_oen_d = 1'b0;
            sda_o_d   = 1'b1;
            busy_d    = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                StDevAddr, StPtr, StWrData: begin
                    if (bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                StRdAck: shift_d = {shift_q[6:0], sda_lvl};
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                StDevAddr: begin
                    if (bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == my_dev_address) begin
                            state_d   = StDevAck;
                            sda_oen_d = 1'b1;
                            sda_o_d   = I2C_ACK;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                StDevAck: begin
                    sda_oen_d = 1'b0;
                    sda_o_d   = 1'b1;
                    bit_cnt_d = '0;
                    if (shift_q[0]) begin
                        state_d     = StRdData;
                        rd_strobe_d = 1'b1;
                        sda_oen_d   = 1'b1;
                        sda_o_d     = rd_data[7];
                        tx_d        = {rd_data[6:0], 1'b0};
                    end else begin
                        state_d = StPtr;
                    end
                end
                StPtr: begin
                    if (bit_cnt_q == 4'd8) begin
                        if (32'(shift_q) < NUM_REGS) begin
                            ptr_d     = shift_q[PTR_W-1:0];
                            state_d   = StPtrAck;
                            sda_oen_d = 1'b1;
                            sda_o_d   = I2C_ACK;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                StPtrAck, StWrAck: begin
                    sda_oen_d = 1'b0;
                    sda_o_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StWrData;
                end
                StWrData: begin
                    if (bit_cnt_q == 4'd8) begin
                        state_d   = StWrAck;
                        sda_oen_d = 1'b1;
                        sda_o_d   = I2C_ACK;
                        wr_ena_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = shift_q;
                        ptr_d     = ptr_inc;
                    end
                end
                StRdData: begin
                    if (bit_cnt_q == 4'd7) begin
                        state_d   = StRdAck;
                        sda_oen_d = 1'b0;
                        sda_o_d   = 1'b1;
                    end else begin
                        sda_o_d   = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                StRdAck: begin
                    if (shift_q[0] == I2C_ACK) begin
                        state_d     = StRdData;
                        bit_cnt_d   = '0;
                        rd_strobe_d = 1'b1;
                        sda_oen_d   = 1'b1;
                        sda_o_d     = rd_data[7];
                        tx_d        = {rd_data[6:0], 1'b0};
                    end else begin
                        state_d = StIgnore;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            sda_o_q     <= 1'b1;
            sda_oen_q   <= 1'b0;
            wr_ena_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            sda_o_q     <= sda_o_d;
            sda_oen_q   <= sda_oen_d;
            wr_ena_q    <= wr_ena_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_strobe_q <= rd_strobe_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_o     = sda_o_q;
    assign sda_oen   = sda_oen_q;
    assign wr_ena    = wr_ena_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_addr   = ptr_q;
    assign rd_strobe = rd_strobe_q;
    assign busy      = busy_q;

endmodule
